// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - command, register-file read port and byte stream of the dump reader
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              Start;
    logic [ADDR_W-1:0] First_Reg;
    logic [ADDR_W-1:0] Last_Reg;
    logic [ADDR_W-1:0] Rd_Reg;
    logic [DATA_W-1:0] Rd_Data;
    logic [7:0]        Byte_Out;
    logic              Byte_Valid;
    logic              Byte_Ready;
    logic              Busy;
    logic              Done;
    logic              Error;

    modport master (
        input  Start, First_Reg, Last_Reg, Rd_Data, Byte_Ready,
        output Rd_Reg, Byte_Out, Byte_Valid, Busy, Done, Error
    );

    modport slave (
        output Start, First_Reg, Last_Reg, Rd_Data, Byte_Ready,
        input  Rd_Reg, Byte_Out, Byte_Valid, Busy, Done, Error
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range and streams header + 4 data bytes per register
module regfile_dump_reader #(
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32
) (
    input  logic                    Sys_Clock,
    input  logic                    Reset,
    regfile_dump_reader_if.master   bus
);
    localparam logic [ADDR_W-1:0] MAX_REG = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rd_reg_q, rd_reg_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] snap_q, snap_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        byte_q, byte_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic xfer;
    logic range_ok;
    logic final_reg;

    assign xfer      = valid_q & bus.Byte_Ready;
    assign range_ok  = bus.First_Reg <= bus.Last_Reg;
    // Stopping at MAX_REG as well guarantees the index can never wrap to 0.
    assign final_reg = (rd_reg_q == last_q) || (rd_reg_q == MAX_REG);

    always_ff @(posedge Sys_Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start && range_ok) state_d = READ;
            READ:    state_d = SEND;
            SEND:    if (xfer && idx_q == 3'd4) state_d = final_reg ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_reg_d = rd_reg_q;
        last_d   = last_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    if (!range_ok) begin
                        error_d = 1'b1;
                    end else begin
                        rd_reg_d = bus.First_Reg;
                        last_d   = bus.Last_Reg;
                        busy_d   = 1'b1;
                    end
                end
            end
            READ: begin
                snap_d  = bus.Rd_Data;
                byte_d  = {2'b10, rd_reg_q};
                valid_d = 1'b1;
                idx_d   = 3'd0;
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != 3'd4) begin
                        case (idx_q)
                            3'd0:    byte_d = snap_q[31:24];
                            3'd1:    byte_d = snap_q[23:16];
                            3'd2:    byte_d = snap_q[15:8];
                            default: byte_d = snap_q[7:0];
                        endcase
                        idx_d = idx_q + 3'd1;
                    end else begin
                        valid_d = 1'b0;
                        if (final_reg) begin
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end else begin
                            rd_reg_d = rd_reg_q + ADDR_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Sys_Clock or posedge Reset) begin
        if (Reset) begin
            rd_reg_q <= '0;
            last_q   <= '0;
            snap_q   <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            rd_reg_q <= rd_reg_d;
            last_q   <= last_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.Rd_Reg     = rd_reg_q;
    assign bus.Byte_Out   = byte_q;
    assign bus.Byte_Valid = valid_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
endmodule
